// File: rtl/risc16_mc_control.sv
// Multi-cycle control unit for the RiSC-16 datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB per instruction, counts retirements and parks in HALT.
module risc16_mc_control #(
   parameter int ALU_FUNCT_LEN = 2,
   parameter int COUNT_LEN     = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [2:0]               opcode,
   input  logic                     imm_nz,
   input  logic                     alu_zero,
   input  logic                     mem_ack,
   output logic                     ir_we,
   output logic                     pc_we,
   output logic                     aluout_we,
   output logic                     mdr_we,
   output logic                     rf_we,
   output logic [1:0]               pc_src,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic                     mem_addr_sel,
   output logic [ALU_FUNCT_LEN-1:0] alu_funct,
   output logic                     alu_src1_sel,
   output logic [1:0]               alu_src2_sel,
   output logic [1:0]               rf_wdata_sel,
   output logic                     halted,
   output logic [2:0]               fsm_state,
   output logic [COUNT_LEN-1:0]     instr_count
);

   // ALU function encodings shared with the datapath ALU.
   localparam logic [ALU_FUNCT_LEN-1:0] ALU_ADD   = ALU_FUNCT_LEN'(0);
   localparam logic [ALU_FUNCT_LEN-1:0] ALU_NAND  = ALU_FUNCT_LEN'(1);
   localparam logic [ALU_FUNCT_LEN-1:0] ALU_PASSA = ALU_FUNCT_LEN'(2);
   localparam logic [ALU_FUNCT_LEN-1:0] ALU_SUB   = ALU_FUNCT_LEN'(3);

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_ADDI = 3'b001;
   localparam logic [2:0] OP_NAND = 3'b010;
   localparam logic [2:0] OP_LUI  = 3'b011;
   localparam logic [2:0] OP_SW   = 3'b100;
   localparam logic [2:0] OP_LW   = 3'b101;
   localparam logic [2:0] OP_BEQ  = 3'b110;
   localparam logic [2:0] OP_JALR = 3'b111;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5
   } state_t;

   state_t                 state_q;
   state_t                 state_d;
   logic                   halted_q;
   logic [COUNT_LEN-1:0]   count_q;
   logic                   retire;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= FETCH;
         halted_q <= 1'b0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         halted_q <= halted_q | (state_d == HALT);
         if (retire) begin
            count_q <= count_q + COUNT_LEN'(1);
         end
      end
   end

   // Memory handshake: mem_req stays high in FETCH/MEM until the cycle mem_ack is seen;
   // the transfer completes on that cycle's rising edge, and ack is ignored elsewhere.
   always_comb begin
      state_d      = state_q;
      retire       = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      aluout_we    = 1'b0;
      mdr_we       = 1'b0;
      rf_we        = 1'b0;
      pc_src       = 2'b00;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      alu_funct    = ALU_ADD;
      alu_src1_sel = 1'b0;
      alu_src2_sel = 2'b00;
      rf_wdata_sel = 2'b00;

      case (state_q)
         FETCH: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = DECODE;
            end
         end
         DECODE: begin
            state_d = EXEC;
         end
         EXEC: begin
            case (opcode)
               OP_ADD: begin
                  aluout_we = 1'b1;
                  state_d   = WB;
               end
               OP_ADDI: begin
                  alu_src2_sel = 2'b01;
                  aluout_we    = 1'b1;
                  state_d      = WB;
               end
               OP_NAND: begin
                  alu_funct = ALU_NAND;
                  aluout_we = 1'b1;
                  state_d   = WB;
               end
               OP_LUI: begin
                  alu_funct    = ALU_PASSA;
                  alu_src1_sel = 1'b1;
                  aluout_we    = 1'b1;
                  state_d      = WB;
               end
               OP_SW, OP_LW: begin
                  alu_src2_sel = 2'b01;
                  aluout_we    = 1'b1;
                  state_d      = MEM;
               end
               OP_BEQ: begin
                  alu_funct    = ALU_SUB;
                  alu_src2_sel = 2'b10;
                  if (alu_zero) begin
                     pc_we  = 1'b1;
                     pc_src = 2'b01;
                  end
                  retire  = 1'b1;
                  state_d = FETCH;
               end
               OP_JALR: begin
                  retire = 1'b1;
                  if (imm_nz) begin
                     state_d = HALT;
                  end else begin
                     // PC was already incremented in FETCH, so it is the link value.
                     alu_funct    = ALU_PASSA;
                     rf_we        = 1'b1;
                     rf_wdata_sel = 2'b10;
                     pc_we        = 1'b1;
                     pc_src       = 2'b10;
                     state_d      = FETCH;
                  end
               end
               default: state_d = FETCH;
            endcase
         end
         MEM: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            mem_we       = (opcode == OP_SW);
            if (mem_ack) begin
               if (opcode == OP_LW) begin
                  mdr_we  = 1'b1;
                  state_d = WB;
               end else begin
                  retire  = 1'b1;
                  state_d = FETCH;
               end
            end
         end
         WB: begin
            rf_we        = 1'b1;
            rf_wdata_sel = (opcode == OP_LW) ? 2'b01 : 2'b00;
            retire       = 1'b1;
            state_d      = FETCH;
         end
         HALT: begin
            state_d = HALT;
         end
         default: state_d = FETCH;
      endcase

      // Reset kills any outstanding request immediately, not at the next edge.
      if (rst) begin
         state_d   = FETCH;
         retire    = 1'b0;
         ir_we     = 1'b0;
         pc_we     = 1'b0;
         aluout_we = 1'b0;
         mdr_we    = 1'b0;
         rf_we     = 1'b0;
         mem_req   = 1'b0;
         mem_we    = 1'b0;
      end
   end

   assign halted      = halted_q;
   assign fsm_state   = state_q;
   assign instr_count = count_q;

endmodule

// File: tb/tb_risc16_mc_control.sv
// Bench for risc16_mc_control: random and directed instruction streams checked cycle by
// cycle against a phase-list reference model built from the instruction timing rules.
module tb_risc16_mc_control;

   localparam int CW = 8;

   localparam int P_FETCH  = 0;
   localparam int P_DECODE = 1;
   localparam int P_EXEC   = 2;
   localparam int P_MEM    = 3;
   localparam int P_WB     = 4;
   localparam int P_HALT   = 5;

   localparam logic [1:0] F_ADD   = 2'd0;
   localparam logic [1:0] F_NAND  = 2'd1;
   localparam logic [1:0] F_PASSA = 2'd2;
   localparam logic [1:0] F_SUB   = 2'd3;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_ADDI = 3'd1;
   localparam logic [2:0] OP_NAND = 3'd2;
   localparam logic [2:0] OP_LUI  = 3'd3;
   localparam logic [2:0] OP_SW   = 3'd4;
   localparam logic [2:0] OP_LW   = 3'd5;
   localparam logic [2:0] OP_BEQ  = 3'd6;
   localparam logic [2:0] OP_JALR = 3'd7;

   typedef struct packed {
      logic          ir_we;
      logic          pc_we;
      logic          aluout_we;
      logic          mdr_we;
      logic          rf_we;
      logic [1:0]    pc_src;
      logic          mem_req;
      logic          mem_we;
      logic          mem_addr_sel;
      logic [1:0]    alu_funct;
      logic          src1;
      logic [1:0]    src2;
      logic [1:0]    wsel;
      logic          halted;
      logic [2:0]    st;
      logic [CW-1:0] cnt;
   } ctl_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [2:0]    opcode;
   logic          imm_nz;
   logic          alu_zero;
   logic          mem_ack;
   logic          ir_we, pc_we, aluout_we, mdr_we, rf_we;
   logic [1:0]    pc_src;
   logic          mem_req, mem_we, mem_addr_sel;
   logic [1:0]    alu_funct;
   logic          alu_src1_sel;
   logic [1:0]    alu_src2_sel;
   logic [1:0]    rf_wdata_sel;
   logic          halted;
   logic [2:0]    fsm_state;
   logic [CW-1:0] instr_count;
   ctl_t          obs;

   int            checks = 0;
   int            errors = 0;
   logic [CW-1:0] model_cnt = '0;

   always #5 clk = ~clk;

   risc16_mc_control #(.ALU_FUNCT_LEN(2), .COUNT_LEN(CW)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .imm_nz(imm_nz), .alu_zero(alu_zero),
      .mem_ack(mem_ack), .ir_we(ir_we), .pc_we(pc_we), .aluout_we(aluout_we),
      .mdr_we(mdr_we), .rf_we(rf_we), .pc_src(pc_src), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr_sel(mem_addr_sel), .alu_funct(alu_funct), .alu_src1_sel(alu_src1_sel),
      .alu_src2_sel(alu_src2_sel), .rf_wdata_sel(rf_wdata_sel), .halted(halted),
      .fsm_state(fsm_state), .instr_count(instr_count)
   );

   assign obs = {ir_we, pc_we, aluout_we, mdr_we, rf_we, pc_src, mem_req, mem_we, mem_addr_sel,
                 alu_funct, alu_src1_sel, alu_src2_sel, rf_wdata_sel, halted, fsm_state,
                 instr_count};

   function automatic ctl_t expect_ctl(int ph, logic [2:0] op, logic imm, logic z, logic ack,
                                       logic [CW-1:0] cnt);
      ctl_t e;
      e           = '0;
      e.st        = 3'(ph);
      e.cnt       = cnt;
      e.alu_funct = F_ADD;
      case (ph)
         P_FETCH: begin
            e.mem_req = 1'b1;
            e.ir_we   = ack;
            e.pc_we   = ack;
         end
         P_EXEC: begin
            if (op <= OP_LW) e.aluout_we = 1'b1;
            if (op == OP_ADDI || op == OP_SW || op == OP_LW) e.src2 = 2'b01;
            if (op == OP_NAND) e.alu_funct = F_NAND;
            if (op == OP_LUI) begin
               e.alu_funct = F_PASSA;
               e.src1      = 1'b1;
            end
            if (op == OP_BEQ) begin
               e.alu_funct = F_SUB;
               e.src2      = 2'b10;
               e.pc_we     = z;
               e.pc_src    = z ? 2'b01 : 2'b00;
            end
            if (op == OP_JALR && !imm) begin
               e.alu_funct = F_PASSA;
               e.rf_we     = 1'b1;
               e.wsel      = 2'b10;
               e.pc_we     = 1'b1;
               e.pc_src    = 2'b10;
            end
         end
         P_MEM: begin
            e.mem_req      = 1'b1;
            e.mem_addr_sel = 1'b1;
            e.mem_we       = (op == OP_SW);
            e.mdr_we       = ack && (op == OP_LW);
         end
         P_WB: begin
            e.rf_we = 1'b1;
            e.wsel  = (op == OP_LW) ? 2'b01 : 2'b00;
         end
         P_HALT: e.halted = 1'b1;
         default: ;
      endcase
      return e;
   endfunction

   task automatic check(input string tag, input ctl_t o, input ctl_t e);
      checks++;
      assert (o === e)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h (state %0d vs %0d, count %0d vs %0d)",
                tag, o, e, o.st, e.st, o.cnt, e.cnt);
      end
   endtask

   // Entered and left just after a rising edge. The phase list is built from the
   // per-instruction timing: fetch waits, decode, exec, memory waits, writeback.
   task automatic do_instr(input logic [2:0] op, input logic imm, input logic z,
                           input int fw, input int mw, input bit abort);
      int            ph[$];
      bit            last;
      bit            halting;
      logic [CW-1:0] cnt_after;
      ctl_t          e;
      halting   = (op == OP_JALR) && imm;
      cnt_after = model_cnt + 1'b1;
      for (int i = 0; i <= fw; i++) ph.push_back(P_FETCH);
      ph.push_back(P_DECODE);
      ph.push_back(P_EXEC);
      if (op == OP_SW || op == OP_LW) for (int i = 0; i <= mw; i++) ph.push_back(P_MEM);
      if (op != OP_SW && op != OP_BEQ && op != OP_JALR) ph.push_back(P_WB);
      if (halting) for (int i = 0; i < 20; i++) ph.push_back(P_HALT);
      for (int k = 0; k < ph.size(); k++) begin
         last     = (k == ph.size() - 1) || (ph[k+1] != ph[k]);
         opcode   = (ph[k] <= P_DECODE) ? 3'($urandom_range(0, 7)) : op;
         imm_nz   = (ph[k] <= P_DECODE) ? 1'($urandom_range(0, 1)) : imm;
         alu_zero = (ph[k] == P_EXEC) ? z : 1'($urandom_range(0, 1));
         if (ph[k] == P_FETCH || ph[k] == P_MEM) mem_ack = last && !(abort && ph[k] == P_MEM);
         else mem_ack = 1'($urandom_range(0, 1));
         #1;
         e = expect_ctl(ph[k], op, imm, z, mem_ack, (ph[k] == P_HALT) ? cnt_after : model_cnt);
         check($sformatf("op%0d_ph%0d", op, ph[k]), obs, e);
         if (abort && ph[k] == P_MEM) begin
            rst = 1'b1;
            #1;
            check("rst_mid_mem", obs, '0);
            @(posedge clk);
            #1;
            rst       = 1'b0;
            model_cnt = '0;
            return;
         end
         @(posedge clk);
         #1;
      end
      model_cnt = cnt_after;
   endtask

   task automatic pulse_reset(input string tag);
      rst = 1'b1;
      #1;
      check(tag, obs, '0);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      model_cnt = '0;
   endtask

   initial begin
      logic [2:0] op;
      ctl_t       e;
      rst      = 1'b1;
      opcode   = '0;
      imm_nz   = 1'b0;
      alu_zero = 1'b0;
      mem_ack  = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset_state", obs, '0);
      rst = 1'b0;

      // ADD with zero-wait memory, then LW with two memory wait cycles, then both BEQ outcomes.
      do_instr(OP_ADD, 1'b0, 1'b0, 0, 0, 1'b0);
      do_instr(OP_LW, 1'b0, 1'b0, 0, 2, 1'b0);
      do_instr(OP_BEQ, 1'b0, 1'b1, 0, 0, 1'b0);
      do_instr(OP_BEQ, 1'b0, 1'b0, 0, 0, 1'b0);
      do_instr(OP_JALR, 1'b0, 1'b0, 1, 0, 1'b0);

      for (int n = 0; n < 60; n++) begin
         op = 3'($urandom_range(0, 7));
         do_instr(op, 1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                  $urandom_range(0, 2), 1'b0);
      end

      // Reset in the middle of a stalled SW memory access.
      do_instr(OP_SW, 1'b0, 1'b0, 0, 3, 1'b1);
      do_instr(OP_SW, 1'b0, 1'b0, 0, 1, 1'b0);

      // Counter wrap.
      pulse_reset("rst_before_wrap");
      for (int n = 0; n < 255; n++) do_instr(OP_ADD, 1'b0, 1'b0, 0, 0, 1'b0);
      e       = '0;
      e.cnt   = '1;
      e.mem_req = 1'b1;
      mem_ack = 1'b0;
      #1;
      check("count_all_ones", obs, e);
      #1;
      do_instr(OP_ADD, 1'b0, 1'b0, 0, 0, 1'b0);
      mem_ack = 1'b0;
      e.cnt   = '0;
      #1;
      check("count_wrapped", obs, e);
      #1;

      // Halting JALR, held 20 cycles, then released by reset.
      do_instr(OP_JALR, 1'b1, 1'b0, 0, 0, 1'b0);
      pulse_reset("rst_from_halt");
      do_instr(OP_ADDI, 1'b0, 1'b0, 0, 0, 1'b0);
      do_instr(OP_NAND, 1'b0, 1'b0, 2, 0, 1'b0);
      do_instr(OP_LUI, 1'b0, 1'b0, 0, 0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
